// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
// Issues one request at a time, holds the returned instruction in the IF
// register until downstream consumes it, and steers fetch on redirects.
// A redirect that arrives while a request is in flight marks the returning
// data for discard so the stale instruction is never delivered.
// Optional feature macro: FETCH_PERF_EN adds request and stall counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;
  logic        discard;
  logic        discard_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_inst_nxt;
  logic [31:0] redirect_tgt;

  // Instructions are word aligned, so the low two target bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential successor; the 32-bit add wraps naturally at the top of memory.
  function automatic logic [31:0] next_seq(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  assign redirect_tgt = align_word(redirect_pc);

  // Request interface: only the REQ state presents an address to memory.
  assign inst_req  = (state == S_REQ);
  assign inst_addr = fetch_pc;

  // Next-state and IF-register update logic; redirect outranks everything else.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    if_valid_nxt = if_valid;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;

    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
        end
        state_nxt = S_REQ;
      end

      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
          if (inst_addr_ok) begin
            // The old address was already accepted; its data must be dropped.
            discard_nxt = 1'b1;
            state_nxt   = S_WAIT;
          end
        end else if (inst_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
          if (inst_data_ok) begin
            // Stale data returns in the same cycle: drop it, nothing remains in flight.
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (inst_data_ok) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            if_valid_nxt = 1'b1;
            if_pc_nxt    = fetch_pc;
            if_inst_nxt  = inst_rdata;
            fetch_pc_nxt = next_seq(fetch_pc);
            state_nxt    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          if_valid_nxt = 1'b0;
          fetch_pc_nxt = redirect_tgt;
          state_nxt    = S_REQ;
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, fetch PC, discard flag and IF register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0000_0000;
      if_inst  <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
      if_valid <= if_valid_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: accepted requests and cycles a valid instruction is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_req_cnt   <= 32'h0000_0000;
      perf_stall_cnt <= 32'h0000_0000;
    end else begin
      if (inst_req && inst_addr_ok) begin
        perf_req_cnt <= perf_req_cnt + 32'd1;
      end
      if (if_valid && stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed checks, a wrap-around fetch on a
// second instance, and a randomized memory responder with a scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rstn_w;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  logic        w_inst_req;
  logic [31:0] w_inst_addr;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_inst;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] w_perf_req_cnt;
  logic [31:0] w_perf_stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
`ifdef FETCH_PERF_EN
    , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rstn(rstn_w), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(w_inst_req), .inst_addr(w_inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst)
`ifdef FETCH_PERF_EN
    , .perf_req_cnt(w_perf_req_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
  );

  typedef struct {
    bit          rst;
    bit          stl;
    bit          rv;
    logic [31:0] rpc;
    bit          aok;
    bit          dok;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    bit          chk_pi;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } deliv_t;

  vec_t   tbl[$];
  vec_t   exp_q[$];
  deliv_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit stl, input bit rv, input logic [31:0] rpc,
                     input bit aok, input bit dok, input logic [31:0] rdata,
                     input bit e_req, input logic [31:0] e_addr, input bit e_vld,
                     input bit chk_pi, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.chk_pi = chk_pi; v.e_pc = e_pc; v.e_inst = e_inst;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
  endtask

  initial begin
    vec_t        e;
    logic [31:0] exp_addr;
    logic [31:0] pend_addr;
    bit          pending;
    bit          prev_vld;
    int          delivered;
    deliv_t      d;

    rstn = 1'b0;
    rstn_w = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    //   rst stl rv rpc          aok dok rdata          req addr          vld chk pc            inst
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h0,        32'h0);         // 0 reset
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 0, 32'h0,        32'h0);         // 1 IDLE->REQ
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 0, 32'h0,        32'h0);         // 2 addr_ok late
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 3 accept
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 4 data_ok late
    add(0, 0, 0, 32'h0,        0, 1, 32'h2001_0001, 0, 32'h0,        1, 1, 32'h0,        32'h2001_0001); // 5 deliver
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,        0, 0, 32'h0,        32'h0);         // 6 consume
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 7
    add(0, 0, 0, 32'h0,        0, 1, 32'h1111_1111, 0, 32'h0,        1, 1, 32'h4,        32'h1111_1111); // 8
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 1, 32'h4,        32'h1111_1111); // 9 stall
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 1, 32'h4,        32'h1111_1111); // 10 stall
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 1, 32'h4,        32'h1111_1111); // 11 stall
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h8,        0, 0, 32'h0,        32'h0);         // 12 release
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 13
    add(0, 0, 1, 32'h103,      0, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 14 redirect in WAIT
    add(0, 0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 1, 32'h100,      0, 0, 32'h0,        32'h0);         // 15 dropped
    add(0, 0, 1, 32'h40,       1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 16 redirect+addr_ok
    add(0, 0, 0, 32'h0,        0, 1, 32'hBAD0_BAD0, 1, 32'h40,       0, 0, 32'h0,        32'h0);         // 17 dropped
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 18
    add(0, 0, 0, 32'h0,        0, 1, 32'h1234_5678, 0, 32'h0,        1, 1, 32'h40,       32'h1234_5678); // 19
    add(0, 1, 1, 32'h200,      0, 0, 32'h0,         1, 32'h200,      0, 0, 32'h0,        32'h0);         // 20 redirect in HOLD
    add(0, 0, 1, 32'h300,      0, 0, 32'h0,         1, 32'h300,      0, 0, 32'h0,        32'h0);         // 21 redirect in REQ
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 22
    add(0, 0, 1, 32'h50,       0, 1, 32'hCAFE_F00D, 1, 32'h50,       0, 0, 32'h0,        32'h0);         // 23 redirect+data_ok
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 24
    add(0, 0, 0, 32'h0,        0, 1, 32'h0BAD_CAFE, 0, 32'h0,        1, 1, 32'h50,       32'h0BAD_CAFE); // 25 not discarded
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h54,       0, 0, 32'h0,        32'h0);         // 26
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 27 into WAIT
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h0,        32'h0);         // 28 reset in WAIT
    add(0, 0, 0, 32'h0,        0, 1, 32'hFFFF_0000, 1, 32'h0,        0, 0, 32'h0,        32'h0);         // 29 stray in IDLE
    add(0, 0, 0, 32'h0,        0, 1, 32'hFFFF_0000, 1, 32'h0,        0, 0, 32'h0,        32'h0);         // 30 stray in REQ
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 31
    add(0, 0, 0, 32'h0,        0, 1, 32'h0000_0077, 0, 32'h0,        1, 1, 32'h0,        32'h0000_0077); // 32
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h0,        32'h0);         // 33 reset in HOLD
    add(0, 0, 1, 32'h1237,     0, 0, 32'h0,         1, 32'h1234,     0, 0, 32'h0,        32'h0);         // 34 redirect in IDLE
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);         // 35
    add(0, 0, 0, 32'h0,        0, 1, 32'h0000_0055, 0, 32'h0,        1, 1, 32'h1234,     32'h0000_0055); // 36
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h1238,     0, 0, 32'h0,        32'h0);         // 37

    for (int i = 0; i < tbl.size(); i++) begin
      rstn           = !tbl[i].rst;
      stall          = tbl[i].stl;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      inst_addr_ok   = tbl[i].aok;
      inst_data_ok   = tbl[i].dok;
      inst_rdata     = tbl[i].rdata;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d_inst_req", i), {31'b0, inst_req}, {31'b0, e.e_req});
      if (e.e_req) chk($sformatf("row%0d_inst_addr", i), inst_addr, e.e_addr);
      chk($sformatf("row%0d_if_valid", i), {31'b0, if_valid}, {31'b0, e.e_vld});
      if (e.chk_pi) begin
        chk($sformatf("row%0d_if_pc", i), if_pc, e.e_pc);
        chk($sformatf("row%0d_if_inst", i), if_inst, e.e_inst);
      end
`ifdef FETCH_PERF_EN
      if (i == 11) begin
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_req_cnt", perf_req_cnt, 32'd2);
      end
`endif
    end

    // Wrap-around fetch from the top of the address space.
    idle_inputs();
    rstn_w = 1'b1;
    @(posedge clk); #1;
    chk("wrap_req", {31'b0, w_inst_req}, 32'd1);
    chk("wrap_addr0", w_inst_addr, 32'hFFFF_FFFC);
    inst_addr_ok = 1'b1;
    @(posedge clk); #1;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    inst_data_ok = 1'b0;
    chk("wrap_vld", {31'b0, w_if_valid}, 32'd1);
    chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_inst", w_if_inst, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    chk("wrap_req2", {31'b0, w_inst_req}, 32'd1);
    chk("wrap_addr1", w_inst_addr, 32'h0000_0000);
    rstn_w = 1'b0;

    // Randomized memory responder against a delivery scoreboard.
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_addr  = 32'h0;
    pend_addr = 32'h0;
    pending   = 1'b0;
    prev_vld  = 1'b0;
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      stall        = ($urandom_range(0, 1) == 1);
      inst_addr_ok = inst_req && ($urandom_range(0, 2) == 0);
      inst_data_ok = pending && ($urandom_range(0, 1) == 1);
      if (inst_data_ok) inst_rdata = memval(pend_addr);
      if (inst_addr_ok) begin
        chk($sformatf("rnd_addr%0d", c), inst_addr, exp_addr);
        d.pc = exp_addr;
        d.inst = memval(exp_addr);
        sb_q.push_back(d);
        pend_addr = exp_addr;
        exp_addr  = exp_addr + 32'd4;
      end
      @(posedge clk); #1;
      if (inst_addr_ok) pending = 1'b1;
      else if (inst_data_ok) pending = 1'b0;
      if (if_valid && !prev_vld) begin
        if (sb_q.size() == 0) begin
          chk("rnd_unexpected_delivery", 32'd1, 32'd0);
        end else begin
          d = sb_q.pop_front();
          chk($sformatf("rnd_pc%0d", delivered), if_pc, d.pc);
          chk($sformatf("rnd_inst%0d", delivered), if_inst, d.inst);
          delivered++;
        end
      end
      prev_vld = if_valid;
    end
    chk("rnd_enough_deliveries", {31'b0, (delivered >= 10)}, 32'd1);
    chk("rnd_outstanding", {31'b0, (sb_q.size() <= 1)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
